keypad_bcd_entry: RTL and testbench

Parametrised successor to the keypad priority encoder in the timer-entry path. Priority-encodes N key lines (highest index wins), debounces press and release, and shifts each accepted digit into an N-digit BCD entry register (e.g. MM:SS for the microwave timer). Sits between the raw keypad inputs and the timer load logic. Emits a one-cycle strobe per accepted digit.

---
 rtl/timer_entry_pkg.sv | 6 +
 rtl/key_prio_encoder.sv | 16 +
 rtl/keypad_bcd_entry.sv | 113 +++++++++++
 tb/tb_keypad_bcd_entry.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/timer_entry_pkg.sv
// timer_entry_pkg: shared FSM states and constants for keypad timer entry
package timer_entry_pkg;
  localparam int BCD_W = 4;
  localparam int MAX_KEYS = 10;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;
endpackage

// File: rtl/key_prio_encoder.sv
// key_prio_encoder: highest-index-wins encoder of N_KEYS key lines to BCD
module key_prio_encoder
  import timer_entry_pkg::*;
#(
  parameter int N_KEYS = MAX_KEYS
) (
  input  logic [N_KEYS-1:0] i_keys,
  output logic              o_any,
  output logic [BCD_W-1:0]  o_code
);
  always_comb begin
    o_code = '0;
    for (int i = 0; i < N_KEYS; i++) o_code = i_keys[i] ? BCD_W'(i) : o_code;
  end
  assign o_any = |i_keys;
endmodule

// File: rtl/keypad_bcd_entry.sv
// keypad_bcd_entry: debounced keypad digit entry into an N-digit BCD shift register
module keypad_bcd_entry
  import timer_entry_pkg::*;
#(
  parameter int N_KEYS = 10,
  parameter int N_DIGITS = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_KEYS-1:0]           keys,
  input  logic                        en,
  input  logic                        clear,
  output logic [BCD_W*N_DIGITS-1:0]   digits,
  output logic                        digit_valid,
  output logic [BCD_W-1:0]            key_code,
  output logic [3:0]                  count,
  output logic                        full,
  output logic                        nonzero
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  logic [N_KEYS-1:0] r_sync1, r_sync2;
  logic w_any, w_accept, w_take;
  logic [BCD_W-1:0] w_code, r_cand, w_cand;
  logic [CW-1:0] r_cnt, w_cnt;
  state_e r_state, w_state;
  logic [BCD_W*N_DIGITS-1:0] w_shift;
  key_prio_encoder #(.N_KEYS(N_KEYS)) u_enc (
    .i_keys(r_sync2),
    .o_any (w_any),
    .o_code(w_code)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_state <= IDLE;
      r_cnt <= '0;
      r_cand <= '0;
    end else begin
      r_sync1 <= keys;
      r_sync2 <= r_sync1;
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_cand <= w_cand;
    end
  end
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_cand = r_cand;
    w_accept = 1'b0;
    case (r_state)
      IDLE: if (w_any) begin
        w_state = PRESS_DB;
        w_cand = w_code;
        w_cnt = CW'(1);
      end
      PRESS_DB: if (!w_any) w_state = IDLE;
        else if (w_code != r_cand) begin
          w_cand = w_code;
          w_cnt = CW'(1);
        end else if (r_cnt == CNT_MAX) begin
          w_state = HELD;
          w_accept = 1'b1;
        end else w_cnt = r_cnt + 1'b1;
      HELD: if (!w_any) begin
        w_state = RELEASE_DB;
        w_cnt = CW'(1);
      end
      RELEASE_DB: if (w_any) w_state = HELD;
        else if (r_cnt == CNT_MAX) w_state = IDLE;
        else w_cnt = r_cnt + 1'b1;
      default: w_state = IDLE;
    endcase
    if (!en) begin
      w_state = IDLE;
      w_cnt = '0;
      w_accept = 1'b0;
    end
  end
  generate
    if (N_DIGITS == 1) begin : g_one
      assign w_shift = r_cand;
    end else begin : g_many
      assign w_shift = {digits[BCD_W*(N_DIGITS-1)-1:0], r_cand};
    end
  endgenerate
  // a press accepted while full is consumed without touching the register
  assign w_take = w_accept && !full;
  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= '0;
      count <= '0;
      key_code <= '0;
      digit_valid <= 1'b0;
    end else if (clear) begin
      digits <= '0;
      count <= '0;
      digit_valid <= 1'b0;
    end else begin
      digit_valid <= w_take;
      if (w_take) begin
        digits <= w_shift;
        count <= count + 1'b1;
        key_code <= r_cand;
      end
    end
  end
  assign full = count == 4'(N_DIGITS);
  assign nonzero = |digits;
endmodule

// File: tb/tb_keypad_bcd_entry.sv
// tb_keypad_bcd_entry: scoreboard bench for keypad_bcd_entry with directed key sequences
module tb_keypad_bcd_entry;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, clear = 1'b0;
  logic [9:0] keys = '0;
  logic [15:0] digits;
  logic digit_valid, full, nonzero;
  logic [3:0] key_code, count;
  int vectors = 0, miscompares = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_e;
  always #5 clk = ~clk;
  keypad_bcd_entry #(.N_KEYS(10), .N_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .keys(keys), .en(en), .clear(clear),
    .digits(digits), .digit_valid(digit_valid), .key_code(key_code),
    .count(count), .full(full), .nonzero(nonzero)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && digit_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected digit_valid: digits=%h key_code=%0d count=%0d, expected no strobe", digits, key_code, count);
      end else begin
        exp_e = exp_q.pop_front();
        check("digit {digits,key_code,count}", {8'h0, digits, key_code, count}, {8'h0, exp_e});
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input int k, input int hold);
    keys = 10'(1) << k;
    tick(hold);
    keys = '0;
    tick(10);
  endtask
  task automatic latency(input string name, input int exp_lat);
    int lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (digit_valid && lat == 0) lat = i;
    end
    check(name, lat, exp_lat);
  endtask
  initial begin
    tick(2);
    check("reset digits", digits, 0);
    check("reset count", count, 0);
    check("reset key_code", key_code, 0);
    check("reset digit_valid", digit_valid, 0);
    check("reset full", full, 0);
    check("reset nonzero", nonzero, 0);
    rst = 1'b0;
    exp_q.push_back({16'h0005, 4'd5, 4'd1});
    keys = 10'(1) << 5;
    latency("key5 latency", 7);
    keys = '0;
    tick(10);
    check("key5 digits", digits, 16'h0005);
    exp_q.push_back({16'h0057, 4'd7, 4'd2});
    keys = (10'(1) << 3) | (10'(1) << 7);
    tick(10);
    keys = 10'(1) << 3;
    tick(15);
    keys = '0;
    tick(10);
    check("priority count", count, 2);
    check("priority key_code", key_code, 7);
    repeat (5) begin
      keys = 10'(1) << 2;
      tick(2);
      keys = '0;
      tick(2);
    end
    exp_q.push_back({16'h0572, 4'd2, 4'd3});
    press(2, 8);
    check("bounce count", count, 3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear digits", digits, 0);
    check("clear count", count, 0);
    check("clear holds key_code", key_code, 2);
    exp_q.push_back({16'h0001, 4'd1, 4'd1});
    press(1, 8);
    exp_q.push_back({16'h0012, 4'd2, 4'd2});
    press(2, 8);
    exp_q.push_back({16'h0123, 4'd3, 4'd3});
    press(3, 8);
    check("not yet full", full, 0);
    exp_q.push_back({16'h1230, 4'd0, 4'd4});
    press(0, 8);
    check("saturate digits", digits, 16'h1230);
    check("saturate count", count, 4);
    check("full", full, 1);
    check("nonzero", nonzero, 1);
    press(9, 8);
    check("full press digits", digits, 16'h1230);
    check("full press key_code", key_code, 0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("cleared nonzero", nonzero, 0);
    keys = 10'(1) << 4;
    tick(6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("collision digits", digits, 0);
    check("collision count", count, 0);
    check("collision digit_valid", digit_valid, 0);
    check("collision key_code", key_code, 0);
    tick(4);
    keys = '0;
    tick(10);
    exp_q.push_back({16'h0004, 4'd4, 4'd1});
    press(4, 8);
    check("fresh press digits", digits, 16'h0004);
    keys = 10'(1) << 6;
    tick(4);
    en = 1'b0;
    keys = '0;
    tick(10);
    en = 1'b1;
    tick(2);
    check("en drop count", count, 1);
    en = 1'b0;
    keys = 10'(1) << 6;
    tick(10);
    check("en low held count", count, 1);
    exp_q.push_back({16'h0046, 4'd6, 4'd2});
    en = 1'b1;
    latency("re-enable latency", 5);
    keys = '0;
    tick(10);
    exp_q.push_back({16'h0468, 4'd8, 4'd3});
    keys = 10'(1) << 8;
    tick(9);
    rst = 1'b1;
    tick(1);
    check("rst-in-held digits", digits, 0);
    check("rst-in-held count", count, 0);
    check("rst-in-held key_code", key_code, 0);
    check("rst-in-held digit_valid", digit_valid, 0);
    check("rst-in-held full", full, 0);
    check("rst-in-held nonzero", nonzero, 0);
    rst = 1'b0;
    exp_q.push_back({16'h0008, 4'd8, 4'd1});
    latency("post-reset latency", 7);
    keys = '0;
    tick(10);
    check("pending expected digits", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
